gray_rx_checker: RTL and testbench

Receive-side companion to the 4-bit Gray counter `gc`. It samples a Gray-coded count, decodes it to binary, and checks that each accepted sample is a legal single step: the same value, or +1 modulo 2^WIDTH. It reports lock once the incoming sequence is stable and counts sequence errors. It sits at the consumer end of a Gray-coded count bus, for example after a synchronizer in another clock domain.

---
 rtl/gray_rx_checker.sv | 128 ++++++++++++
 tb/tb_gray_rx_checker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_rx_checker.sv
// Gray-coded count receiver: decodes each accepted sample, classifies the
// step against the previous value, tracks lock and counts sequence errors.
module gray_rx_checker #(
   parameter int WIDTH  = 4,
   parameter int LOCK_N = 4,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             gray_valid,
   input  logic             clr_err,
   output logic [WIDTH-1:0] bin_out,
   output logic             bin_valid,
   output logic             step_err,
   output logic             locked,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      LOCKD = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_V = 4'(LOCK_N);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [3:0]       run_q, run_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic             bin_valid_q, bin_valid_d;
   logic             step_err_q, step_err_d;
   logic [CNT_W-1:0] err_q, err_d;

   logic [WIDTH-1:0] dec;
   logic [WIDTH-1:0] prev_inc;
   logic [3:0]       run_inc;
   logic             good, hold, bad, flag;

   always_comb begin
      dec = '0;
      dec[WIDTH-1] = gray_in[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         dec[i] = dec[i+1] ^ gray_in[i];
      end
   end

   assign prev_inc = prev_q + WIDTH'(1);
   assign run_inc  = run_q + 4'd1;
   assign good     = (dec == prev_inc);
   assign hold     = (dec == prev_q);
   assign bad      = !good && !hold;
   // The first sample after IDLE has no predecessor, so it is never an error.
   assign flag     = gray_valid && (state_q != IDLE) && bad;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         prev_q      <= '0;
         run_q       <= '0;
         bin_q       <= '0;
         bin_valid_q <= 1'b0;
         step_err_q  <= 1'b0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         run_q       <= run_d;
         bin_q       <= bin_d;
         bin_valid_q <= bin_valid_d;
         step_err_q  <= step_err_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      prev_d  = prev_q;
      if (gray_valid) begin
         prev_d = dec;
         unique case (state_q)
            IDLE: begin
               state_d = TRACK;
               run_d   = '0;
            end
            TRACK: begin
               if (good) begin
                  run_d = run_inc;
                  if (run_inc >= LOCK_V) state_d = LOCKD;
               end else if (bad) begin
                  run_d = '0;
               end
            end
            LOCKD: begin
               if (bad) begin
                  run_d   = '0;
                  state_d = TRACK;
               end
            end
            default: begin
               state_d = IDLE;
               run_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      bin_d       = gray_valid ? dec : bin_q;
      bin_valid_d = gray_valid;
      step_err_d  = flag;
      err_d       = err_q;
      if (clr_err) begin
         err_d = flag ? CNT_W'(1) : '0;
      end else if (flag && (err_q != {CNT_W{1'b1}})) begin
         err_d = err_q + CNT_W'(1);
      end
   end

   assign bin_out   = bin_q;
   assign bin_valid = bin_valid_q;
   assign step_err  = step_err_q;
   assign locked    = (state_q == LOCKD);
   assign err_count = err_q;

endmodule

// File: tb/tb_gray_rx_checker.sv
// Bench for gray_rx_checker: directed scenarios plus random traffic,
// checked every cycle against an arithmetic reference model.
module tb_gray_rx_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] gray_in = '0;
   logic       gray_valid = 1'b0;
   logic       clr_err = 1'b0;
   logic [3:0] bin_out;
   logic       bin_valid;
   logic       step_err;
   logic       locked;
   logic [7:0] err_count;

   int n_cmp = 0;
   int n_bad = 0;

   gray_rx_checker #(.WIDTH(4), .LOCK_N(4), .CNT_W(8)) dut (
      .clk(clk),
      .reset(reset),
      .gray_in(gray_in),
      .gray_valid(gray_valid),
      .clr_err(clr_err),
      .bin_out(bin_out),
      .bin_valid(bin_valid),
      .step_err(step_err),
      .locked(locked),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   // reference model state
   bit m_first = 1'b1;
   int m_prev = 0;
   int m_run = 0;
   int m_bin = 0;
   bit m_bv = 1'b0;
   bit m_se = 1'b0;
   bit m_lock = 1'b0;
   int m_err = 0;

   function automatic int g2b(input logic [3:0] g);
      int b;
      b = 0;
      for (int s = 0; s < 4; s++) b = b ^ (int'(g) >> s);
      return b & 15;
   endfunction

   function automatic logic [3:0] b2g(input int b);
      logic [3:0] v;
      v = 4'(b);
      return v ^ (v >> 1);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_first = 1'b1; m_prev = 0; m_run = 0; m_bin = 0;
         m_bv = 1'b0; m_se = 1'b0; m_lock = 1'b0; m_err = 0;
      end else begin
         int d;
         bit is_bad;
         is_bad = 1'b0;
         m_bv = gray_valid;
         m_se = 1'b0;
         if (gray_valid) begin
            d = g2b(gray_in);
            if (m_first) begin
               m_first = 1'b0;
               m_run = 0;
            end else if (d == (m_prev + 1) % 16) begin
               m_run = (m_run + 1 > 4) ? 4 : m_run + 1;
               if (m_run >= 4) m_lock = 1'b1;
            end else if (d != m_prev) begin
               is_bad = 1'b1;
               m_run = 0;
               m_lock = 1'b0;
            end
            m_prev = d;
            m_bin = d;
         end
         m_se = is_bad;
         if (clr_err) m_err = is_bad ? 1 : 0;
         else if (is_bad) m_err = (m_err + 1 > 255) ? 255 : m_err + 1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("bin_out", int'(bin_out), m_bin);
      chk("bin_valid", int'(bin_valid), int'(m_bv));
      chk("step_err", int'(step_err), int'(m_se));
      chk("locked", int'(locked), int'(m_lock));
      chk("err_count", int'(err_count), m_err);
   end

   task automatic send_g(input logic v, input logic [3:0] g, input logic c);
      gray_valid = v;
      gray_in = g;
      clr_err = c;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic v, input int b, input logic c);
      send_g(v, b2g(b), c);
   endtask

   initial begin
      reset = 1'b0;
      repeat (2) send(1'b0, 0, 1'b0);
      chk("rst_bin", int'(bin_out), 0);
      chk("rst_lock", int'(locked), 0);
      reset = 1'b1;

      // lock-up on 0000,0001,0011,0010,0110
      send_g(1'b1, 4'b0000, 1'b0); chk("lk_bin0", int'(bin_out), 0);
      send_g(1'b1, 4'b0001, 1'b0); chk("lk_bin1", int'(bin_out), 1);
      send_g(1'b1, 4'b0011, 1'b0); chk("lk_bin2", int'(bin_out), 2);
      send_g(1'b1, 4'b0010, 1'b0); chk("lk_bin3", int'(bin_out), 3);
      chk("lk_early", int'(locked), 0);
      send_g(1'b1, 4'b0110, 1'b0); chk("lk_bin4", int'(bin_out), 4);
      chk("lk_lock", int'(locked), 1);
      chk("lk_err", int'(err_count), 0);

      // wrap 14 -> 15 -> 0
      for (int b = 5; b <= 14; b++) send(1'b1, b, 1'b0);
      send_g(1'b1, 4'b1000, 1'b0); chk("wr_bin15", int'(bin_out), 15);
      send_g(1'b1, 4'b0000, 1'b0); chk("wr_bin0", int'(bin_out), 0);
      chk("wr_lock", int'(locked), 1);
      chk("wr_serr", int'(step_err), 0);

      // skip 1 -> 3
      send_g(1'b1, 4'b0001, 1'b0);
      send_g(1'b1, 4'b0010, 1'b0);
      chk("sk_serr", int'(step_err), 1);
      chk("sk_bin", int'(bin_out), 3);
      chk("sk_lock", int'(locked), 0);
      chk("sk_err", int'(err_count), 1);
      for (int b = 4; b <= 6; b++) send(1'b1, b, 1'b0);
      chk("sk_nolock", int'(locked), 0);
      send(1'b1, 7, 1'b0);
      chk("sk_relock", int'(locked), 1);

      // hold on 0011 with gaps
      for (int b = 8; b <= 17; b++) send(1'b1, b % 16, 1'b0);
      for (int k = 0; k < 3; k++) begin
         send_g(1'b1, 4'b0011, 1'b0);
         chk("hd_bv", int'(bin_valid), 1);
         if (k < 2) begin
            send(1'b0, 0, 1'b0);
            send(1'b0, 0, 1'b0);
            chk("hd_gap_bv", int'(bin_valid), 0);
         end
      end
      chk("hd_lock", int'(locked), 1);
      chk("hd_err", int'(err_count), 1);

      // second error, relock, then mid-cycle reset
      send(1'b1, 9, 1'b0);
      for (int b = 10; b <= 13; b++) send(1'b1, b, 1'b0);
      chk("mr_err2", int'(err_count), 2);
      chk("mr_lock", int'(locked), 1);
      gray_valid = 1'b0;
      #1 reset = 1'b0;
      #1;
      chk("mr_bin", int'(bin_out), 0);
      chk("mr_lock0", int'(locked), 0);
      chk("mr_err0", int'(err_count), 0);
      chk("mr_bv", int'(bin_valid), 0);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      send_g(1'b1, 4'b0101, 1'b0);
      chk("mr_first", int'(bin_out), 6);
      chk("mr_serr", int'(step_err), 0);

      // saturation and clear-with-error
      for (int k = 0; k < 256; k++) send(1'b1, (m_prev + 2) % 16, 1'b0);
      chk("sat_255", int'(err_count), 255);
      send(1'b1, (m_prev + 2) % 16, 1'b0);
      chk("sat_hold", int'(err_count), 255);
      send(1'b1, (m_prev + 2) % 16, 1'b1);
      chk("clr_bad", int'(err_count), 1);
      send(1'b0, 0, 1'b1);
      chk("clr_only", int'(err_count), 0);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         int p, b;
         logic v, c;
         v = ($urandom_range(0, 99) < 80);
         p = $urandom_range(0, 9);
         if (p < 6) b = (m_prev + 1) % 16;
         else if (p < 8) b = m_prev;
         else b = $urandom_range(0, 15);
         c = ($urandom_range(0, 31) == 0);
         send(v, b, c);
         if ($urandom_range(0, 399) == 0) begin
            #1 reset = 1'b0;
            #2 reset = 1'b1;
         end
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
